// File: rtl/tlul_pkg.sv
// tlul_pkg: minimal TL-UL types shared by hosts, devices and the crossbar.
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;
  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;
  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;
  // instr_type 4'h9 marks a data (non-instruction) access
  localparam tl_a_user_t TL_A_USER_DEFAULT = '{rsvd: '0, instr_type: 4'h9, cmd_intg: '0, data_intg: '0};
  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/tlul_mem_initiator_if.sv
// tlul_mem_initiator_if: simple req/gnt memory port; master drives requests, slave answers.
interface tlul_mem_initiator_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata, err, busy);
  modport slave (input req, we, addr, wdata, be, output gnt, rvalid, rdata, err, busy);
endinterface

// File: rtl/tlul_mem_initiator_resp.sv
// tlul_mem_initiator_resp: registers a D beat into a one-cycle rvalid/rdata/err response.
module tlul_mem_initiator_resp (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        d_valid_i,
  input  logic [31:0] d_data_i,
  input  logic        d_err_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= d_valid_i;
      rdata_q  <= d_valid_i ? d_data_i : '0;
      err_q    <= d_valid_i & d_err_i;
    end
  end
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
endmodule

// File: rtl/tlul_mem_initiator.sv
// tlul_mem_initiator: turns a req/gnt memory port into in-order TL-UL A requests and
// D-channel response pulses, tracking outstanding transactions and ordering errors.
module tlul_mem_initiator
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SourceW        = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  tlul_mem_initiator_if.slave mem,
  output tl_h2d_t tl_h_o,
  input  tl_d2h_t tl_h_i
);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  logic [SourceW-1:0] src_q, src_d, exp_q, exp_d, step;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               a_valid, gnt, d_acc, d_err;
  // source IDs wrap at MaxOutstanding; with a single slot they stay at 0
  assign step    = SourceW'(MaxOutstanding > 1);
  assign a_valid = mem.req && (cnt_q != CntW'(MaxOutstanding));
  assign gnt     = a_valid && tl_h_i.a_ready;
  assign d_acc   = tl_h_i.d_valid && (cnt_q != '0);
  assign d_err   = tl_h_i.d_error | (tl_h_i.d_source[SourceW-1:0] != exp_q) | (cnt_q == '0);
  always_comb begin
    src_d = gnt ? src_q + step : src_q;
    exp_d = d_acc ? exp_q + step : exp_q;
    cnt_d = (gnt && !d_acc) ? cnt_q + CntW'(1) : (!gnt && d_acc) ? cnt_q - CntW'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q <= '0;
      exp_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      exp_q <= exp_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = a_valid;
    tl_h_o.a_opcode  = !mem.we ? Get : (mem.be == 4'hF) ? PutFullData : PutPartialData;
    tl_h_o.a_size    = TL_SZW'(2);
    tl_h_o.a_source  = TL_AIW'(src_q);
    tl_h_o.a_address = {mem.addr[31:2], 2'b00};
    tl_h_o.a_mask    = mem.we ? mem.be : 4'hF;
    tl_h_o.a_data    = mem.wdata;
    tl_h_o.a_user    = TL_A_USER_DEFAULT;
    tl_h_o.d_ready   = 1'b1;
  end
  assign mem.gnt  = gnt;
  assign mem.busy = cnt_q != '0;
  tlul_mem_initiator_resp u_resp (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .d_valid_i (tl_h_i.d_valid),
    .d_data_i  ((tl_h_i.d_opcode == AccessAckData) ? tl_h_i.d_data : 32'h0),
    .d_err_i   (d_err),
    .rvalid_o  (mem.rvalid),
    .rdata_o   (mem.rdata),
    .err_o     (mem.err)
  );
endmodule

// File: tb/tb_tlul_mem_initiator.sv
// tb_tlul_mem_initiator: directed bench with an in-order SRAM-like TL-UL device model.
module tb_tlul_mem_initiator;
  import tlul_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  tlul_mem_initiator_if mif();
  tl_h2d_t tl_h;
  tl_d2h_t tl_d;
  tlul_mem_initiator #(.MaxOutstanding(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .mem    (mif),
    .tl_h_o (tl_h),
    .tl_h_i (tl_d)
  );
  int n_cmp = 0, n_err = 0, n_rv = 0, n_rv_err = 0;
  logic stall = 1'b0, man = 1'b0, man_v = 1'b0, man_err = 1'b0;
  logic [7:0] man_src = '0;
  logic dv = 1'b0;
  logic [2:0] dop = '0;
  logic [31:0] ddat = '0;
  logic [7:0] dsrc = '0;
  logic [31:0] mem [16];
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] data;
    logic [7:0]  src;
  } rsp_t;
  rsp_t q[$];
  rsp_t r_tmp;
  always_comb begin
    tl_d          = '0;
    tl_d.a_ready  = 1'b1;
    tl_d.d_valid  = man ? man_v : dv;
    tl_d.d_opcode = man ? AccessAckData : tl_d_op_e'(dop);
    tl_d.d_data   = man ? 32'hBAD0_0000 : ddat;
    tl_d.d_source = man ? man_src : dsrc;
    tl_d.d_error  = man && man_err;
  end
  // device: accepts every A beat, answers in order one cycle later unless stalled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      dv <= 1'b0;
    end else begin
      if (tl_h.a_valid && tl_d.a_ready) begin
        if (tl_h.a_opcode == Get) q.push_back('{AccessAckData, mem[tl_h.a_address[5:2]], tl_h.a_source});
        else begin
          for (int b = 0; b < 4; b++)
            if (tl_h.a_mask[b]) mem[tl_h.a_address[5:2]][8*b+:8] = tl_h.a_data[8*b+:8];
          q.push_back('{AccessAck, 32'h0, tl_h.a_source});
        end
      end
      if (!man) begin
        if (!stall && q.size() != 0) begin
          r_tmp = q.pop_front();
          dv   <= 1'b1;
          dop  <= r_tmp.op;
          ddat <= r_tmp.data;
          dsrc <= r_tmp.src;
        end else dv <= 1'b0;
      end
    end
  end
  always @(negedge clk) if (mif.rvalid) begin
    n_rv++;
    if (mif.err) n_rv_err++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic req_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                        output logic [2:0] op, output logic [3:0] mask, output logic [7:0] src, output logic [31:0] aa);
    int k = 0;
    @(negedge clk);
    mif.req = 1'b1; mif.we = we; mif.addr = addr; mif.wdata = wdata; mif.be = be;
    #1;
    while (!mif.gnt && k < 20) begin @(negedge clk); #1; k++; end
    check("grant_timeout", 64'(k < 20), 1);
    op = tl_h.a_opcode; mask = tl_h.a_mask; src = tl_h.a_source; aa = tl_h.a_address;
    @(negedge clk);
    mif.req = 1'b0;
  endtask
  task automatic wait_rsp(output logic [31:0] rdata, output logic err);
    int k = 0;
    while (!mif.rvalid && k < 20) begin @(negedge clk); k++; end
    check("rsp_timeout", 64'(k < 20), 1);
    rdata = mif.rdata; err = mif.err;
    @(negedge clk);
    check("rvalid_pulse", mif.rvalid, 0);
  endtask
  task automatic inject(input logic [7:0] src, input logic e, output logic rv, output logic err);
    @(negedge clk);
    man_v = 1'b1; man_src = src; man_err = e;
    @(negedge clk);
    man_v = 1'b0;
    rv = mif.rvalid; err = mif.err;
  endtask
  initial begin
    logic [2:0] op;
    logic [3:0] mk;
    logic [7:0] sr;
    logic [31:0] aa, rd;
    logic e, rv;
    int rv0, re0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mif.req = 1'b0; mif.we = 1'b0; mif.addr = '0; mif.wdata = '0; mif.be = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rvalid", mif.rvalid, 0);
    check("rst_rdata", mif.rdata, 0);
    check("rst_err", mif.err, 0);
    check("rst_busy", mif.busy, 0);
    check("rst_avalid", tl_h.a_valid, 0);
    check("rst_dready", tl_h.d_ready, 1);
    rst_n = 1'b1;
    // single full write
    req_op(1, 32'h100, 32'hDEADBEEF, 4'hF, op, mk, sr, aa);
    check("w1_op", op, PutFullData);
    check("w1_mask", mk, 4'hF);
    check("w1_src", sr, 0);
    wait_rsp(rd, e);
    check("w1_rdata", rd, 0);
    check("w1_err", e, 0);
    // read-back, with address low bits set to confirm they are dropped
    req_op(0, 32'h103, 32'h0, 4'h0, op, mk, sr, aa);
    check("r1_op", op, Get);
    check("r1_mask", mk, 4'hF);
    check("r1_src", sr, 1);
    check("r1_addr", aa, 32'h100);
    wait_rsp(rd, e);
    check("r1_rdata", rd, 32'hDEADBEEF);
    check("r1_err", e, 0);
    check("r1_busy", mif.busy, 0);
    // partial write then read
    req_op(1, 32'h104, 32'h12345678, 4'b0011, op, mk, sr, aa);
    check("pw_op", op, PutPartialData);
    check("pw_mask", mk, 4'h3);
    wait_rsp(rd, e);
    req_op(0, 32'h107, 32'h0, 4'h0, op, mk, sr, aa);
    check("pr_addr", aa, 32'h104);
    wait_rsp(rd, e);
    check("pr_rdata", rd, 32'h00005678);
    // saturation at two outstanding
    stall = 1'b1; rv0 = n_rv; re0 = n_rv_err;
    @(negedge clk);
    mif.req = 1'b1; mif.we = 1'b0; mif.addr = 32'h100; mif.be = 4'h0;
    #1 check("sat_gnt1", mif.gnt, 1);
    check("sat_src1", tl_h.a_source, 0);
    @(negedge clk); #1 check("sat_gnt2", mif.gnt, 1);
    check("sat_src2", tl_h.a_source, 1);
    @(negedge clk); #1 check("sat_full_avalid", tl_h.a_valid, 0);
    check("sat_full_gnt", mif.gnt, 0);
    check("sat_busy", mif.busy, 1);
    @(negedge clk); #1 check("sat_hold_avalid", tl_h.a_valid, 0);
    stall = 1'b0;
    @(negedge clk); #1 check("sat_dbeat_dvalid", tl_d.d_valid, 1);
    check("sat_dbeat_avalid", tl_h.a_valid, 0);
    @(negedge clk); #1 check("sat_gnt3", mif.gnt, 1);
    check("sat_src3", tl_h.a_source, 0);
    @(negedge clk);
    mif.req = 1'b0;
    repeat (5) @(negedge clk);
    check("sat_rsp_count", 64'(n_rv - rv0), 3);
    check("sat_rsp_errs", 64'(n_rv_err - re0), 0);
    check("sat_idle", mif.busy, 0);
    // d_error on an expected beat (source 1 outstanding)
    stall = 1'b1;
    req_op(0, 32'h100, 32'h0, 4'h0, op, mk, sr, aa);
    check("e1_src", sr, 1);
    man = 1'b1;
    inject(8'd1, 1'b1, rv, e);
    check("e1_rvalid", rv, 1);
    check("e1_err", e, 1);
    q.delete();
    // source mismatch: exp is 0, beat carries 1
    req_op(0, 32'h100, 32'h0, 4'h0, op, mk, sr, aa);
    inject(8'd1, 1'b0, rv, e);
    check("e2_rvalid", rv, 1);
    check("e2_err", e, 1);
    q.delete();
    check("e2_busy", mif.busy, 0);
    // unsolicited beat whose source would otherwise match
    inject(8'd1, 1'b0, rv, e);
    check("e3_rvalid", rv, 1);
    check("e3_err", e, 1);
    check("e3_busy", mif.busy, 0);
    man = 1'b0; stall = 1'b0;
    req_op(0, 32'h104, 32'h0, 4'h0, op, mk, sr, aa);
    wait_rsp(rd, e);
    check("e3_after_err", e, 0);
    check("e3_after_rdata", rd, 32'h00005678);
    // reset with two requests in flight
    stall = 1'b1;
    req_op(0, 32'h100, 32'h0, 4'h0, op, mk, sr, aa);
    req_op(0, 32'h104, 32'h0, 4'h0, op, mk, sr, aa);
    check("rf_busy_before", mif.busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rf_busy", mif.busy, 0);
    check("rf_rvalid", mif.rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    req_op(1, 32'h108, 32'hCAFEF00D, 4'hF, op, mk, sr, aa);
    check("rf_src", sr, 0);
    wait_rsp(rd, e);
    check("rf_err", e, 0);
    man = 1'b1;
    inject(8'd0, 1'b0, rv, e);
    check("late_rvalid", rv, 1);
    check("late_err", e, 1);
    man = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
